// File: rtl/cr16_pkg.sv
// Shared CR16 core definitions: default datapath widths and the fetch FSM states.
package cr16_pkg;

  localparam int unsigned CR16_ADDRESS_WIDTH = 16;
  localparam int unsigned CR16_DATA_WIDTH    = 16;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_slot.sv
// One buffered instruction: {data, address, valid}. Load wins over clear so a
// slot can be emptied by a transfer and refilled in the same cycle. Data and
// address only change on load, which keeps them stable while stalled.
module fetch_slot
  import cr16_pkg::*;
#(
  parameter int unsigned P_ADDRESS_WIDTH = CR16_ADDRESS_WIDTH,
  parameter int unsigned P_DATA_WIDTH    = CR16_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       load_i,
  input  logic                       clear_i,
  input  logic [P_DATA_WIDTH-1:0]    data_i,
  input  logic [P_ADDRESS_WIDTH-1:0] addr_i,
  output logic [P_DATA_WIDTH-1:0]    data_o,
  output logic [P_ADDRESS_WIDTH-1:0] addr_o,
  output logic                       valid_o
);

  logic [P_DATA_WIDTH-1:0]    data_q, data_d;
  logic [P_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                       valid_q, valid_d;

  // Next-state: load takes priority, otherwise clear only drops valid.
  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      addr_d  = addr_i;
      valid_d = 1'b1;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers with synchronous reset to an empty, zeroed slot.
  always_ff @(posedge clk) begin
    if (srst) begin
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// CR16 instruction fetch stage: issues one read per PC value, buffers up to two
// returned words (output + hold slot) and hands them to decode over valid/ready.
// A flush empties both slots and drains any read still in flight.
module instr_fetch
  import cr16_pkg::*;
#(
  parameter int unsigned P_ADDRESS_WIDTH = CR16_ADDRESS_WIDTH,
  parameter int unsigned P_DATA_WIDTH    = CR16_DATA_WIDTH
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic [P_ADDRESS_WIDTH-1:0] I_PC_ADDRESS,
  output logic                       O_PC_ENABLE,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic                       O_MEM_READ,
  input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA,
  input  logic                       I_MEM_VALID,
  input  logic                       I_FLUSH,
  output logic [P_DATA_WIDTH-1:0]    O_INSTR,
  output logic [P_ADDRESS_WIDTH-1:0] O_INSTR_ADDRESS,
  output logic                       O_INSTR_VALID,
  input  logic                       I_INSTR_READY
);

  fetch_state_t               state_q, state_d;
  logic [P_ADDRESS_WIDTH-1:0] addr_q, addr_d;

  logic                       out_load, out_clear, out_from_hold;
  logic                       hold_load, hold_clear;
  logic [P_DATA_WIDTH-1:0]    out_data_in;
  logic [P_ADDRESS_WIDTH-1:0] out_addr_in;
  logic [P_DATA_WIDTH-1:0]    hold_data;
  logic [P_ADDRESS_WIDTH-1:0] hold_addr;
  logic                       hold_valid;
  logic                       transfer;

  assign transfer      = O_INSTR_VALID & I_INSTR_READY;
  // The memory address is just the PC; only O_MEM_READ qualifies it.
  assign O_MEM_ADDRESS = I_PC_ADDRESS;
  assign out_data_in   = out_from_hold ? hold_data : I_MEM_DATA;
  assign out_addr_in   = out_from_hold ? hold_addr : addr_q;

  // Next-state and control: reset silences everything, flush beats normal flow.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    O_MEM_READ    = 1'b0;
    O_PC_ENABLE   = 1'b0;
    out_load      = 1'b0;
    out_clear     = 1'b0;
    out_from_hold = 1'b0;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;

    if (I_RESET) begin
      state_d = S_ISSUE;
    end else if (I_FLUSH) begin
      // PC controller loads the branch target on this enable pulse.
      O_PC_ENABLE = 1'b1;
      out_clear   = 1'b1;
      hold_clear  = 1'b1;
      unique case (state_q)
        S_WAIT, S_DRAIN: state_d = I_MEM_VALID ? S_ISSUE : S_DRAIN;
        default:         state_d = S_ISSUE;
      endcase
    end else begin
      out_clear = transfer;
      unique case (state_q)
        S_ISSUE: begin
          // Issue regardless of slot occupancy; the hold slot catches the return.
          O_MEM_READ  = 1'b1;
          O_PC_ENABLE = 1'b1;
          addr_d      = I_PC_ADDRESS;
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          if (I_MEM_VALID) begin
            if (!O_INSTR_VALID || transfer) begin
              out_load = 1'b1;
              state_d  = S_ISSUE;
            end else begin
              hold_load = 1'b1;
              state_d   = S_STALL;
            end
          end
        end
        S_STALL: begin
          if (transfer) begin
            out_load      = hold_valid;
            out_from_hold = 1'b1;
            hold_clear    = 1'b1;
            state_d       = S_ISSUE;
          end
        end
        S_DRAIN: begin
          // Return of the read that was in flight at flush time is dropped.
          if (I_MEM_VALID) begin
            state_d = S_ISSUE;
          end
        end
        default: state_d = S_ISSUE;
      endcase
    end
  end

  // FSM state and outstanding-read address registers.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= S_ISSUE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  fetch_slot #(
    .P_ADDRESS_WIDTH(P_ADDRESS_WIDTH),
    .P_DATA_WIDTH   (P_DATA_WIDTH)
  ) u_out_slot (
    .clk    (I_CLK),
    .srst   (I_RESET),
    .load_i (out_load),
    .clear_i(out_clear),
    .data_i (out_data_in),
    .addr_i (out_addr_in),
    .data_o (O_INSTR),
    .addr_o (O_INSTR_ADDRESS),
    .valid_o(O_INSTR_VALID)
  );

  fetch_slot #(
    .P_ADDRESS_WIDTH(P_ADDRESS_WIDTH),
    .P_DATA_WIDTH   (P_DATA_WIDTH)
  ) u_hold_slot (
    .clk    (I_CLK),
    .srst   (I_RESET),
    .load_i (hold_load),
    .clear_i(hold_clear),
    .data_i (I_MEM_DATA),
    .addr_i (addr_q),
    .data_o (hold_data),
    .addr_o (hold_addr),
    .valid_o(hold_valid)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC and fixed-latency memory.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [15:0] pc;
  logic        pc_en;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        flush = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic        ready = 1'b0;

  logic [15:0] pc_init = 16'h0000;
  logic [15:0] flush_target = 16'h0000;
  int          mem_lat = 1;
  logic        mem_busy;
  int          mem_cnt;
  logic [15:0] mem_paddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .I_CLK          (clk),
    .I_RESET        (srst),
    .I_PC_ADDRESS   (pc),
    .O_PC_ENABLE    (pc_en),
    .O_MEM_ADDRESS  (mem_addr),
    .O_MEM_READ     (mem_read),
    .I_MEM_DATA     (mem_data),
    .I_MEM_VALID    (mem_valid),
    .I_FLUSH        (flush),
    .O_INSTR        (instr),
    .O_INSTR_ADDRESS(instr_addr),
    .O_INSTR_VALID  (instr_valid),
    .I_INSTR_READY  (ready)
  );

  // Program counter: increments on enable, loads the target on a flush enable.
  always @(posedge clk) begin
    if (srst) pc <= pc_init;
    else if (pc_en) pc <= flush ? flush_target : pc + 16'd1;
  end

  // Memory: mem[a] = a ^ 0xA5A5, returned mem_lat cycles after the request.
  always @(posedge clk) begin
    if (srst) begin
      mem_busy  <= 1'b0;
      mem_valid <= 1'b0;
      mem_data  <= 16'h0000;
      mem_cnt   <= 0;
      mem_paddr <= 16'h0000;
    end else begin
      mem_valid <= 1'b0;
      if (mem_read) begin
        if (mem_lat == 1) begin
          mem_valid <= 1'b1;
          mem_data  <= mem_addr ^ 16'hA5A5;
        end else begin
          mem_busy  <= 1'b1;
          mem_cnt   <= mem_lat - 1;
          mem_paddr <= mem_addr;
        end
      end else if (mem_busy) begin
        if (mem_cnt == 1) begin
          mem_valid <= 1'b1;
          mem_data  <= mem_paddr ^ 16'hA5A5;
          mem_busy  <= 1'b0;
        end
        mem_cnt <= mem_cnt - 1;
      end
    end
  end

  // Reset for two edges; returns #1 into cycle C0, the first post-reset cycle.
  task do_reset(input logic [15:0] pc0, input int lat, input logic rdy);
    @(negedge clk);
    srst = 1'b1; flush = 1'b0; ready = rdy; pc_init = pc0; mem_lat = lat;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    #1;
  endtask

  task test_reset;
    @(negedge clk);
    srst = 1'b1; flush = 1'b0; ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b want 0", mem_read); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %0b want 0", pc_en); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
    checks++; if (instr_addr !== 16'h0000) begin errors++; $display("FAIL reset_instr_addr: got %h want 0000", instr_addr); end
    $display("reset: outputs checked while reset held");
  endtask

  task test_stream;
    logic [15:0] ea;
    do_reset(16'h0000, 1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (mem_read !== (k % 2 == 0)) begin errors++; $display("FAIL stream_read c%0d: got %0b want %0b", k, mem_read, (k % 2 == 0)); end
      if (k % 2 == 0) begin
        ea = 16'(k / 2);
        checks++; if (mem_addr !== ea) begin errors++; $display("FAIL stream_mem_addr c%0d: got %h want %h", k, mem_addr, ea); end
      end
      checks++; if (instr_valid !== (k >= 2 && k % 2 == 0)) begin errors++; $display("FAIL stream_valid c%0d: got %0b want %0b", k, instr_valid, (k >= 2 && k % 2 == 0)); end
      if (k >= 2 && k % 2 == 0) begin
        ea = 16'(k / 2 - 1);
        checks++; if (instr_addr !== ea) begin errors++; $display("FAIL stream_addr c%0d: got %h want %h", k, instr_addr, ea); end
        checks++; if (instr !== (ea ^ 16'hA5A5)) begin errors++; $display("FAIL stream_data c%0d: got %h want %h", k, instr, ea ^ 16'hA5A5); end
        $display("stream: c%0d transfer addr=%h data=%h", k, instr_addr, instr);
      end
    end
  endtask

  task test_backpressure;
    int reads;
    reads = 0;
    do_reset(16'h0000, 1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (mem_read === 1'b1) reads++;
    end
    checks++; if (reads != 2) begin errors++; $display("FAIL bp_read_count: got %0d want 2", reads); end
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0000) begin errors++; $display("FAIL bp_held: got v=%0b a=%h want v=1 a=0000", instr_valid, instr_addr); end
    @(negedge clk); ready = 1'b1; #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0000 || instr !== 16'hA5A5) begin errors++; $display("FAIL bp_first: got v=%0b a=%h d=%h want 1/0000/a5a5", instr_valid, instr_addr, instr); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0001 || instr !== 16'hA5A4) begin errors++; $display("FAIL bp_second: got v=%0b a=%h d=%h want 1/0001/a5a4", instr_valid, instr_addr, instr); end
    checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL bp_reissue: got r=%0b a=%h want 1/0002", mem_read, mem_addr); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_gap: got %0b want 0", instr_valid); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0002 || instr !== 16'hA5A7) begin errors++; $display("FAIL bp_third: got v=%0b a=%h d=%h want 1/0002/a5a7", instr_valid, instr_addr, instr); end
    $display("backpressure: reads while stalled=%0d", reads);
  endtask

  task test_flush_outstanding;
    int  n;
    logic found;
    found = 1'b0;
    do_reset(16'h0000, 3, 1'b1);
    for (n = 0; n < 100; n++) begin
      if (mem_read === 1'b1 && mem_addr === 16'h0004) begin found = 1'b1; break; end
      @(negedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL flush_find_issue: got no read to 0004 want one within 100 cycles"); end
    if (found) begin
      @(negedge clk); flush = 1'b1; flush_target = 16'h0040; #1;
      checks++; if (mem_read !== 1'b0 || pc_en !== 1'b1) begin errors++; $display("FAIL flush_cycle: got r=%0b en=%0b want 0/1", mem_read, pc_en); end
      @(negedge clk); flush = 1'b0; #1;
      checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL flush_drain1: got v=%0b r=%0b want 0/0", instr_valid, mem_read); end
      @(negedge clk); #1;
      checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL flush_drain2: got v=%0b r=%0b want 0/0", instr_valid, mem_read); end
      @(negedge clk); #1;
      checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL flush_reissue: got r=%0b a=%h want 1/0040", mem_read, mem_addr); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale c%0d: got %0b want 0", k, instr_valid); end
        @(negedge clk); #1;
      end
      checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0040 || instr !== 16'hA5E5) begin errors++; $display("FAIL flush_target_instr: got v=%0b a=%h d=%h want 1/0040/a5e5", instr_valid, instr_addr, instr); end
      $display("flush_outstanding: next instr addr=%h data=%h", instr_addr, instr);
    end
  endtask

  task test_flush_coincident;
    do_reset(16'h0000, 1, 1'b1);
    @(negedge clk); flush = 1'b1; flush_target = 16'h0080; #1;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL coin_setup: got mem_valid=%0b want 1", mem_valid); end
    checks++; if (mem_read !== 1'b0 || pc_en !== 1'b1) begin errors++; $display("FAIL coin_flush: got r=%0b en=%0b want 0/1", mem_read, pc_en); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL coin_dropped: got %0b want 0", instr_valid); end
    checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0080) begin errors++; $display("FAIL coin_reissue: got r=%0b a=%h want 1/0080", mem_read, mem_addr); end
    repeat (2) @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0080 || instr !== 16'hA525) begin errors++; $display("FAIL coin_target: got v=%0b a=%h d=%h want 1/0080/a525", instr_valid, instr_addr, instr); end
    $display("flush_coincident: next instr addr=%h data=%h", instr_addr, instr);
  endtask

  task test_wrap;
    do_reset(16'hFFFF, 1, 1'b1);
    repeat (2) @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'hFFFF || instr !== 16'h5A5A) begin errors++; $display("FAIL wrap_ffff: got v=%0b a=%h d=%h want 1/ffff/5a5a", instr_valid, instr_addr, instr); end
    repeat (2) @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0000 || instr !== 16'hA5A5) begin errors++; $display("FAIL wrap_0000: got v=%0b a=%h d=%h want 1/0000/a5a5", instr_valid, instr_addr, instr); end
    $display("wrap: addr after ffff=%h", instr_addr);
  endtask

  task test_reset_in_stall;
    do_reset(16'h0000, 1, 1'b0);
    repeat (5) @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL rst_stall_setup: got v=%0b r=%0b want 1/0", instr_valid, mem_read); end
    @(negedge clk); srst = 1'b1; pc_init = 16'h0010; #1;
    checks++; if (mem_read !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL rst_stall_forced: got r=%0b en=%0b want 0/0", mem_read, pc_en); end
    @(negedge clk); srst = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_cleared: got %0b want 0", instr_valid); end
    checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0010) begin errors++; $display("FAIL rst_stall_issue: got r=%0b a=%h want 1/0010", mem_read, mem_addr); end
    @(negedge clk); ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0010 || instr !== 16'hA5B5) begin errors++; $display("FAIL rst_stall_fresh: got v=%0b a=%h d=%h want 1/0010/a5b5", instr_valid, instr_addr, instr); end
    $display("reset_in_stall: first instr addr=%h data=%h", instr_addr, instr);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush_outstanding;
    test_flush_coincident;
    test_wrap;
    test_reset_in_stall;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
